// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM arbiter that puts the instruction-fetch
// (IF) port and the data-memory (DM) port in front of one sram_ctl instance.
package sram_arb_pkg;

  localparam int ADDR_W_DEF        = 24;
  localparam int DATA_W_DEF        = 32;
  localparam int MAX_DM_STREAK_DEF = 4;
  localparam int TIMEOUT_CYC_DEF   = 255;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  // Identity of the port that owns the access in flight
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  localparam logic [3:0] BE_N_NONE = 4'hF;
  localparam logic [3:0] BE_N_ALL  = 4'h0;

  // Only the strobe that matches the access direction counts as completion
  function automatic logic access_done(input logic rw, input logic r_ready,
                                       input logic w_finish);
    return rw ? r_ready : w_finish;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select. DM has priority unless it has used up its
// streak while IF was waiting, in which case IF is served.
module sram_arb_pick (
  input  logic if_req,
  input  logic dm_req,
  input  logic streak_full,
  output logic valid,
  output logic pick_dm
);

  // Priority decode with the IF forward-progress override
  always_comb begin
    valid   = if_req | dm_req;
    pick_dm = dm_req;
    if (if_req && (!dm_req || streak_full)) begin
      pick_dm = 1'b0;
    end
  end

endmodule

// File: rtl/sram_arb.sv
// SRAM arbiter: one access at a time from IF or DM, issued to sram_ctl,
// completed by the matching ready/finish strobe or by the watchdog.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ARB_IDLE  | no access in flight; arbitrate and latch the winner
// ARB_ISSUE | access latched; pulse ctl_start once sram_ctl is not busy
// ARB_WAIT  | waiting for the completion strobe or the watchdog limit
//
// The ack is registered, so the ack cycle is already ARB_IDLE. Arbitration
// is held off during that single cycle: a requester only sees its ack there
// and would otherwise be granted a second time for the same request. A port
// that keeps its request high past the ack is granted again the cycle after.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_DM_STREAK = MAX_DM_STREAK_DEF,
  parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_rw,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be_n,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              err,
  output logic              ctl_start,
  output logic              ctl_rw,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  output logic [3:0]        ctl_be_n,
  input  logic [DATA_W-1:0] ctl_rdata,
  input  logic              ctl_r_ready,
  input  logic              ctl_w_finish,
  input  logic              ctl_busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int STK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DM_STREAK);

  arb_state_e       state;
  arb_state_e       state_nxt;
  gnt_e             gnt_q;
  logic             pick_valid;
  logic             pick_dm;
  logic             streak_full;
  logic [STK_W-1:0] dm_streak;
  logic [TMO_W-1:0] tmo_cnt;
  logic             ack_cycle;
  logic             grant;
  logic             done;
  logic             timeout;

  assign streak_full = (dm_streak == STK_MAX);
  assign ack_cycle   = if_ack | dm_ack;

  sram_arb_pick u_pick (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .streak_full (streak_full),
    .valid       (pick_valid),
    .pick_dm     (pick_dm)
  );

  // Cycle qualifiers derived from the current state. Completion wins over a
  // watchdog expiry that lands on the same cycle.
  assign grant   = (state == ARB_IDLE) && pick_valid && !ack_cycle;
  assign done    = (state == ARB_WAIT) && access_done(ctl_rw, ctl_r_ready, ctl_w_finish);
  assign timeout = (state == ARB_WAIT) && !done && (tmo_cnt >= TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:  if (grant)           state_nxt = ARB_ISSUE;
      ARB_ISSUE: if (!ctl_busy)       state_nxt = ARB_WAIT;
      ARB_WAIT:  if (done || timeout) state_nxt = ARB_IDLE;
      default:                        state_nxt = ARB_IDLE;
    endcase
  end

  // Start pulse: exactly the ISSUE cycle in which sram_ctl is free
  always_comb begin
    ctl_start = 1'b0;
    if (state == ARB_ISSUE) begin
      ctl_start = !ctl_busy;
    end
  end

  // Watchdog: cleared on start, counts WAIT cycles, saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (ctl_start) begin
      tmo_cnt <= '0;
    end else if (state == ARB_WAIT && tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // DM streak: grows only while IF is kept waiting, saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_streak <= '0;
    end else if (grant) begin
      if (!pick_dm || !if_req) begin
        dm_streak <= '0;
      end else if (!streak_full) begin
        dm_streak <= dm_streak + STK_W'(1);
      end
    end
  end

  // Latch the winning request; it is not re-sampled until the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= GNT_IF;
      ctl_rw    <= 1'b0;
      ctl_addr  <= '0;
      ctl_wdata <= '0;
      ctl_be_n  <= BE_N_NONE;
    end else if (grant) begin
      if (pick_dm) begin
        gnt_q     <= GNT_DM;
        ctl_rw    <= dm_rw;
        ctl_addr  <= dm_addr;
        ctl_wdata <= dm_wdata;
        ctl_be_n  <= dm_be_n;
      end else begin
        gnt_q     <= GNT_IF;
        ctl_rw    <= 1'b1;
        ctl_addr  <= if_addr;
        ctl_wdata <= '0;
        ctl_be_n  <= BE_N_ALL;
      end
    end
  end

  // One-cycle ack to the owner, with err flagging a watchdog termination
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      err    <= 1'b0;
    end else begin
      if_ack <= (done || timeout) && (gnt_q == GNT_IF);
      dm_ack <= (done || timeout) && (gnt_q == GNT_DM);
      err    <= timeout;
    end
  end

  // Read data capture; a timed-out access leaves the old data in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else if (done && ctl_rw) begin
      if (gnt_q == GNT_IF) begin
        if_rdata <= ctl_rdata;
      end else begin
        dm_rdata <= ctl_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb. Inputs change on the falling edge and outputs
// are sampled on the falling edge, so every value set at a falling edge is
// what the DUT sees at the following rising edge.
module tb_sram_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [23:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_rw = 1'b0;
  logic [23:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be_n = 4'hF;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        err;
  logic        ctl_start;
  logic        ctl_rw;
  logic [23:0] ctl_addr;
  logic [31:0] ctl_wdata;
  logic [3:0]  ctl_be_n;
  logic [31:0] ctl_rdata = '0;
  logic        ctl_r_ready = 1'b0;
  logic        ctl_w_finish = 1'b0;
  logic        ctl_busy = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arb #(
    .ADDR_W(24), .DATA_W(32), .MAX_DM_STREAK(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_rw(dm_rw), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be_n(dm_be_n), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .err(err),
    .ctl_start(ctl_start), .ctl_rw(ctl_rw), .ctl_addr(ctl_addr),
    .ctl_wdata(ctl_wdata), .ctl_be_n(ctl_be_n), .ctl_rdata(ctl_rdata),
    .ctl_r_ready(ctl_r_ready), .ctl_w_finish(ctl_w_finish), .ctl_busy(ctl_busy)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({if_ack, dm_ack, err, ctl_start, ctl_rw} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000", {if_ack, dm_ack, err, ctl_start, ctl_rw});
    end
    checks++;
    if (ctl_be_n !== 4'hF) begin
      failures++;
      $display("FAIL reset_be_n got=%h want=f", ctl_be_n);
    end
    checks++;
    if ({ctl_addr, ctl_wdata, if_rdata, dm_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h want=0", ctl_addr, ctl_wdata, if_rdata, dm_rdata);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (ctl_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_start got=%b want=0", ctl_start);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    if_req  = 1'b1;
    if_addr = 24'h000040;
    step();
    checks++;
    if (ctl_start !== 1'b1) begin
      failures++;
      $display("FAIL rmw_start got=%b want=1", ctl_start);
    end
    step();
    step();
    rst_n  = 1'b0;
    if_req = 1'b0;
    #1;
    checks++;
    if ({if_ack, dm_ack, err, ctl_start, ctl_rw, ctl_addr} !== '0 || ctl_be_n !== 4'hF) begin
      failures++;
      $display("FAIL rmw_reset_outputs got=%b%b%b%b%b addr=%h be_n=%h want=0 be_n=f",
               if_ack, dm_ack, err, ctl_start, ctl_rw, ctl_addr, ctl_be_n);
    end
    step();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 14; i++) begin
      ctl_r_ready = (i == 2);
      step();
      if (if_ack || dm_ack || err || ctl_start) seen = 1'b1;
    end
    ctl_r_ready = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rmw_no_late_ack got=%b want=0", seen);
    end
  endtask

  task automatic test_if_read();
    if_req  = 1'b1;
    if_addr = 24'h000010;
    step();
    checks++;
    if (ctl_start !== 1'b1) begin
      failures++;
      $display("FAIL if_start got=%b want=1", ctl_start);
    end
    checks++;
    if ({ctl_rw, ctl_addr, ctl_be_n} !== {1'b1, 24'h000010, 4'h0}) begin
      failures++;
      $display("FAIL if_ctl got=%b/%h/%h want=1/000010/0", ctl_rw, ctl_addr, ctl_be_n);
    end
    step();
    checks++;
    if ({ctl_start, if_ack} !== 2'b00) begin
      failures++;
      $display("FAIL if_wait1 got=%b want=00", {ctl_start, if_ack});
    end
    ctl_rdata   = 32'hDEADBEEF;
    ctl_r_ready = 1'b1;
    step();
    ctl_r_ready = 1'b0;
    ctl_rdata   = 32'h0;
    checks++;
    if ({if_ack, dm_ack, err} !== 3'b100) begin
      failures++;
      $display("FAIL if_ack got=%b want=100", {if_ack, dm_ack, err});
    end
    checks++;
    if (if_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL if_rdata got=%h want=deadbeef", if_rdata);
    end
    if_req = 1'b0;
    step();
    checks++;
    if ({if_ack, ctl_start} !== 2'b00 || if_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL if_after got=%b rdata=%h want=00 rdata=deadbeef", {if_ack, ctl_start}, if_rdata);
    end
    step();
    checks++;
    if (ctl_start !== 1'b0) begin
      failures++;
      $display("FAIL if_no_regrant got=%b want=0", ctl_start);
    end
  endtask

  task automatic test_dm_write();
    dm_req   = 1'b1;
    dm_rw    = 1'b0;
    dm_addr  = 24'h000020;
    dm_wdata = 32'h12345678;
    dm_be_n  = 4'b1100;
    step();
    checks++;
    if (ctl_start !== 1'b1) begin
      failures++;
      $display("FAIL dmw_start got=%b want=1", ctl_start);
    end
    checks++;
    if ({ctl_rw, ctl_addr, ctl_wdata, ctl_be_n} !== {1'b0, 24'h000020, 32'h12345678, 4'b1100}) begin
      failures++;
      $display("FAIL dmw_ctl got=%b/%h/%h/%b want=0/000020/12345678/1100",
               ctl_rw, ctl_addr, ctl_wdata, ctl_be_n);
    end
    dm_addr = 24'h0000FF;
    step();
    ctl_r_ready = 1'b1;
    step();
    checks++;
    if (dm_ack !== 1'b0) begin
      failures++;
      $display("FAIL dmw_ignore_rready got=%b want=0", dm_ack);
    end
    ctl_r_ready  = 1'b0;
    ctl_w_finish = 1'b1;
    step();
    ctl_w_finish = 1'b0;
    checks++;
    if ({dm_ack, if_ack, err} !== 3'b100) begin
      failures++;
      $display("FAIL dmw_ack got=%b want=100", {dm_ack, if_ack, err});
    end
    checks++;
    if (ctl_addr !== 24'h000020 || dm_rdata !== 32'h0) begin
      failures++;
      $display("FAIL dmw_latched got=%h rdata=%h want=000020 rdata=0", ctl_addr, dm_rdata);
    end
    dm_req = 1'b0;
    step();
    checks++;
    if (dm_ack !== 1'b0) begin
      failures++;
      $display("FAIL dmw_ack_pulse got=%b want=0", dm_ack);
    end
  endtask

  task automatic test_busy();
    int starts;
    ctl_busy = 1'b1;
    dm_req   = 1'b1;
    dm_rw    = 1'b1;
    dm_addr  = 24'h000030;
    starts   = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ctl_start) starts++;
    end
    checks++;
    if (starts !== 0) begin
      failures++;
      $display("FAIL busy_hold got=%0d starts want=0", starts);
    end
    ctl_busy = 1'b0;
    #1;
    checks++;
    if (ctl_start !== 1'b1) begin
      failures++;
      $display("FAIL busy_release_start got=%b want=1", ctl_start);
    end
    step();
    checks++;
    if (ctl_start !== 1'b0) begin
      failures++;
      $display("FAIL busy_single_start got=%b want=0", ctl_start);
    end
    ctl_rdata   = 32'hCAFEF00D;
    ctl_r_ready = 1'b1;
    step();
    ctl_r_ready = 1'b0;
    checks++;
    if (dm_ack !== 1'b1 || dm_rdata !== 32'hCAFEF00D || err !== 1'b0) begin
      failures++;
      $display("FAIL busy_read_ack got=%b rdata=%h err=%b want=1 rdata=cafef00d err=0",
               dm_ack, dm_rdata, err);
    end
    dm_req = 1'b0;
    step();
  endtask

  task automatic test_streak();
    bit exp_dm [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int n_acks;
    bit pend;
    if_req    = 1'b1;
    if_addr   = 24'h000100;
    dm_req    = 1'b1;
    dm_rw     = 1'b0;
    dm_addr   = 24'h000200;
    ctl_rdata = 32'h11112222;
    n_acks    = 0;
    pend      = 1'b0;
    for (int cyc = 0; cyc < 80 && n_acks < 6; cyc++) begin
      step();
      ctl_r_ready  = 1'b0;
      ctl_w_finish = 1'b0;
      if (pend) begin
        if (ctl_rw) ctl_r_ready = 1'b1;
        else ctl_w_finish = 1'b1;
        pend = 1'b0;
      end
      if (if_ack || dm_ack) begin
        checks++;
        if (dm_ack !== exp_dm[n_acks] || if_ack === dm_ack) begin
          failures++;
          $display("FAIL streak_grant%0d got dm=%b if=%b want dm=%b", n_acks, dm_ack, if_ack,
                   exp_dm[n_acks]);
        end
        n_acks++;
        if (n_acks == 6) begin
          if_req = 1'b0;
          dm_req = 1'b0;
        end
      end
      if (ctl_start) pend = 1'b1;
    end
    checks++;
    if (n_acks !== 6) begin
      failures++;
      $display("FAIL streak_ack_count got=%0d want=6", n_acks);
    end
    checks++;
    if (if_rdata !== 32'h11112222) begin
      failures++;
      $display("FAIL streak_if_rdata got=%h want=11112222", if_rdata);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    ctl_r_ready  = 1'b0;
    ctl_w_finish = 1'b0;
    step();
    step();
  endtask

  task automatic test_timeout();
    int early;
    if_req    = 1'b1;
    if_addr   = 24'h000050;
    ctl_rdata = 32'hBAD0BAD0;
    step();
    checks++;
    if (ctl_start !== 1'b1) begin
      failures++;
      $display("FAIL tmo_start got=%b want=1", ctl_start);
    end
    ctl_w_finish = 1'b1;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if_ack || dm_ack || err) early++;
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL tmo_early got=%0d acks want=0", early);
    end
    step();
    ctl_w_finish = 1'b0;
    checks++;
    if ({if_ack, dm_ack, err} !== 3'b101) begin
      failures++;
      $display("FAIL tmo_ack_err got=%b want=101", {if_ack, dm_ack, err});
    end
    checks++;
    if (if_rdata !== 32'h11112222) begin
      failures++;
      $display("FAIL tmo_rdata_kept got=%h want=11112222", if_rdata);
    end
    if_req = 1'b0;
    step();
    checks++;
    if ({if_ack, err, ctl_start} !== 3'b000) begin
      failures++;
      $display("FAIL tmo_idle got=%b want=000", {if_ack, err, ctl_start});
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_if_read();
    test_dm_write();
    test_busy();
    test_streak();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
